// File: rtl/bpf_fwd_pkg.sv
// Shared types and helpers for the BPF forwarder: FSM states, default widths
// and the final-beat byte-enable mask.
package bpf_fwd_pkg;

  localparam int FWD_ADDR_WIDTH = 10;
  localparam int FWD_LEN_WIDTH  = FWD_ADDR_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    WAIT_LOW
  } fwd_state_e;

  // rem = len mod 8; a partial final beat keeps the top rem bytes (byte 0 is MSB).
  function automatic logic [7:0] keep_mask(input logic [2:0] rem);
    logic [7:0] m;
    case (rem)
      3'd0:    m = 8'hFF;
      3'd1:    m = 8'h80;
      3'd2:    m = 8'hC0;
      3'd3:    m = 8'hE0;
      3'd4:    m = 8'hF0;
      3'd5:    m = 8'hF8;
      3'd6:    m = 8'hFC;
      default: m = 8'hFE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bpf_fwd_skid.sv
// Two-entry FIFO between the packet-memory read port and the output stream.
// The head entry drives the stream outputs and only changes when popped.
module bpf_fwd_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  logic [63:0] i_data,
  input  logic [7:0]  i_keep,
  input  logic        i_last,
  input  logic        i_pop,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_last,
  output logic [1:0]  o_count
);

  logic [63:0] r_data [2];
  logic [7:0]  r_keep [2];
  logic [1:0]  r_last;
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        w_push;
  logic        w_pop;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_keep[i] <= '0;
      end
      r_last  <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= i_data;
        r_keep[r_wptr] <= i_keep;
        r_last[r_wptr] <= i_last;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_data[r_rptr];
  assign o_keep  = r_keep[r_rptr];
  assign o_last  = r_last[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/bpf_forwarder.sv
// Reads an accepted packet out of packet memory and streams it as 64-bit beats,
// then releases the buffer with forwarder_done. BPF_FORWARDER_STATS_EN adds packet/byte counters.
//
// state    | meaning
// IDLE     | waiting for ready_for_forwarder, captures fwd_len
// RUN      | issuing reads and streaming beats until the last handshake
// DONE     | one-cycle forwarder_done pulse
// WAIT_LOW | waiting for ready_for_forwarder to drop before re-arming
module bpf_forwarder
  import bpf_fwd_pkg::*;
#(
  parameter int ADDR_WIDTH = FWD_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready_for_forwarder,
  input  logic [LEN_WIDTH-1:0]  fwd_len,
  output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                  forwarder_rd_en,
  input  logic [63:0]           forwarder_rd_data,
  output logic                  forwarder_done,
  output logic [63:0]           m_tdata,
  output logic [7:0]            m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
`ifdef BPF_FORWARDER_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           byte_count
`endif
);

  localparam int BW = LEN_WIDTH + 1;

  fwd_state_e          r_state;
  fwd_state_e          w_next;
  logic [BW-1:0]       w_beats;
  logic [BW-1:0]       r_rd_left;
  logic [BW-1:0]       r_push_left;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [2:0]          r_rem;
  logic                r_inflight;
  logic                w_start;
  logic                w_rd_en;
  logic                w_done;
  logic                w_pop;
  logic [1:0]          w_occ;
  logic [2:0]          w_credit;
  logic                w_push_last;
  logic [7:0]          w_push_keep;

  assign w_beats = ({1'b0, fwd_len} + BW'(7)) >> 3;
  assign w_pop   = m_tvalid && m_tready;

  // Counting this cycle's pop as free keeps one beat per cycle under full throughput.
  assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_rd_en = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (ready_for_forwarder) begin
          w_start = 1'b1;
          w_next  = (w_beats == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_rd_en = (r_rd_left != '0) && (w_credit < 3'd2);
        if (w_pop && m_tlast) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!ready_for_forwarder) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_left   <= '0;
      r_push_left <= '0;
      r_rd_addr   <= '0;
      r_rem       <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_start) begin
        r_rd_left   <= w_beats;
        r_push_left <= w_beats;
        r_rd_addr   <= '0;
        r_rem       <= fwd_len[2:0];
      end else begin
        if (w_rd_en) begin
          r_rd_left <= r_rd_left - BW'(1);
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        end
        if (r_inflight) r_push_left <= r_push_left - BW'(1);
      end
    end
  end

  assign w_push_last = (r_push_left == BW'(1));
  assign w_push_keep = w_push_last ? keep_mask(r_rem) : 8'hFF;

  bpf_fwd_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (forwarder_rd_data),
    .i_keep  (w_push_keep),
    .i_last  (w_push_last),
    .i_pop   (w_pop),
    .o_valid (m_tvalid),
    .o_data  (m_tdata),
    .o_keep  (m_tkeep),
    .o_last  (m_tlast),
    .o_count (w_occ)
  );

  assign forwarder_rd_en   = w_rd_en;
  assign forwarder_rd_addr = r_rd_addr;
  assign forwarder_done    = w_done;

`ifdef BPF_FORWARDER_STATS_EN
  logic [LEN_WIDTH-1:0] r_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len      <= '0;
      pkt_count  <= '0;
      byte_count <= '0;
    end else begin
      if (w_start) r_len <= fwd_len;
      if (w_done) begin
        pkt_count  <= pkt_count + 32'd1;
        byte_count <= byte_count + 32'(r_len);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bpf_forwarder.sv
// Scoreboard bench for bpf_forwarder: directed packets push expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_bpf_forwarder;

  localparam int AW = 10;
  localparam int LW = AW + 3;

  logic          clk;
  logic          rst;
  logic          ready_for_forwarder;
  logic [LW-1:0] fwd_len;
  logic [AW-1:0] forwarder_rd_addr;
  logic          forwarder_rd_en;
  logic [63:0]   forwarder_rd_data;
  logic          forwarder_done;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
`ifdef BPF_FORWARDER_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   byte_count;
`endif

  bpf_forwarder #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ready_for_forwarder (ready_for_forwarder),
    .fwd_len             (fwd_len),
    .forwarder_rd_addr   (forwarder_rd_addr),
    .forwarder_rd_en     (forwarder_rd_en),
    .forwarder_rd_data   (forwarder_rd_data),
    .forwarder_done      (forwarder_done),
    .m_tdata             (m_tdata),
    .m_tkeep             (m_tkeep),
    .m_tlast             (m_tlast),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready)
`ifdef BPF_FORWARDER_STATS_EN
    ,
    .pkt_count           (pkt_count),
    .byte_count          (byte_count)
`endif
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    done_cnt = 0;
  int    rd_cnt = 0;
  int    tv_cnt = 0;
  int    hs_cnt = 0;
  bit    zero_mode = 0;
  int    rdy_mode = 0;
  logic  prev_last_hs = 0;
  logic  held_valid = 0;
  logic [63:0] held_data = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, 6'b0, a, 16'h5A5A, 6'b0, ~a};
  endfunction

  always @(posedge clk) begin
    if (forwarder_rd_en) forwarder_rd_data <= mem_word(forwarder_rd_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // m_tready driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_tready = 1'b1;
      else begin
        m_tready = pat[ph];
        ph = (ph + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (forwarder_done) begin
        done_cnt++;
        if (!zero_mode) chk("done_after_last", {63'b0, prev_last_hs}, 64'd1);
      end
      if (forwarder_rd_en) rd_cnt++;
      if (m_tvalid) tv_cnt++;
      if (held_valid) begin
        chk("stall_valid", {63'b0, m_tvalid}, 64'd1);
        chk("stall_data", m_tdata, held_data);
      end
      if (m_tvalid && m_tready) begin
        hs_cnt++;
        if (sb.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          beat_t e;
          e = sb.pop_front();
          chk("tdata", m_tdata, e.d);
          chk("tkeep", {56'b0, m_tkeep}, {56'b0, e.k});
          chk("tlast", {63'b0, m_tlast}, {63'b0, e.l});
        end
      end
      prev_last_hs = m_tvalid && m_tready && m_tlast;
      held_valid   = m_tvalid && !m_tready;
      held_data    = m_tdata;
    end else begin
      prev_last_hs = 1'b0;
      held_valid   = 1'b0;
    end
  end

  task automatic push_pkt(input int len, input logic [7:0] fkeep);
    int beats;
    beats = (len + 7) / 8;
    for (int i = 0; i < beats; i++) begin
      beat_t b;
      b.d = mem_word(AW'(i));
      b.k = (i == beats - 1) ? fkeep : 8'hFF;
      b.l = (i == beats - 1);
      sb.push_back(b);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, {63'b0, forwarder_rd_en}, 64'd0);
    chk({tag, "_rd_addr"}, {54'b0, forwarder_rd_addr}, 64'd0);
    chk({tag, "_done"}, {63'b0, forwarder_done}, 64'd0);
    chk({tag, "_tvalid"}, {63'b0, m_tvalid}, 64'd0);
    chk({tag, "_tlast"}, {63'b0, m_tlast}, 64'd0);
    chk({tag, "_tkeep"}, {56'b0, m_tkeep}, 64'd0);
    chk({tag, "_tdata"}, m_tdata, 64'd0);
  endtask

  task automatic run_pkt(input int len, input logic [7:0] fkeep, input int hold, input bit lat);
    int base_done;
    bit got;
    base_done = done_cnt;
    push_pkt(len, fkeep);
    zero_mode = (len == 0);
    fwd_len = LW'(len);
    ready_for_forwarder = 1'b1;
    @(posedge clk);
    #1;
    if (hold == 0) ready_for_forwarder = 1'b0;
    if (lat) begin
      @(negedge clk);
      chk("lat_rd_en", {63'b0, forwarder_rd_en}, 64'd1);
      chk("lat_rd_addr", {54'b0, forwarder_rd_addr}, 64'd0);
      @(negedge clk);
      chk("lat_tvalid_e1", {63'b0, m_tvalid}, 64'd0);
      @(negedge clk);
      chk("lat_tvalid_e2", {63'b0, m_tvalid}, 64'd1);
    end
    got = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base_done) got = 1;
    end
    chk("done_seen", {63'b0, got}, 64'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      ready_for_forwarder = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("done_once", 64'(done_cnt - base_done), 64'd1);
  endtask

  initial begin
    int base_rd, base_tv, base_hs, base_done;
    bit got;
    rst = 1'b0;
    ready_for_forwarder = 1'b0;
    fwd_len = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_pkt(56, 8'hFF, 0, 1'b1);
    run_pkt(21, 8'hF8, 0, 1'b0);
    run_pkt(3, 8'hE0, 0, 1'b0);
    run_pkt(8, 8'hFF, 0, 1'b0);

    base_rd = rd_cnt;
    base_tv = tv_cnt;
    run_pkt(0, 8'hFF, 0, 1'b0);
    chk("zero_no_rd", 64'(rd_cnt - base_rd), 64'd0);
    chk("zero_no_tvalid", 64'(tv_cnt - base_tv), 64'd0);

    rdy_mode = 1;
    run_pkt(64, 8'hFF, 0, 1'b0);
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    base_hs = hs_cnt;
    run_pkt(16, 8'hFF, 20, 1'b0);
    chk("hold_beats", 64'(hs_cnt - base_hs), 64'd2);

    run_pkt(8191, 8'hFE, 0, 1'b0);

    // Abort a 64-byte packet after three beats with reset.
    base_hs = hs_cnt;
    push_pkt(64, 8'hFF);
    zero_mode = 0;
    fwd_len = LW'(64);
    ready_for_forwarder = 1'b1;
    @(posedge clk);
    #1;
    ready_for_forwarder = 1'b0;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      #1;
      if (hs_cnt - base_hs >= 3) got = 1;
    end
    chk("abort_three_beats", {63'b0, got}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base_done = done_cnt;
    @(negedge clk);
    chk_reset_outputs("abort");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - base_done), 64'd0);

    run_pkt(8, 8'hFF, 0, 1'b0);
`ifdef BPF_FORWARDER_STATS_EN
    chk("pkt_count", {32'b0, pkt_count}, 64'd1);
    chk("byte_count", {32'b0, byte_count}, 64'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
